// File: rtl/duc_bypass_ctrl_if.sv
// Handshake and config bundle between the DUC bypass controller and its surroundings.
// slave: controller side; master: driving environment side.
interface duc_bypass_ctrl_if #(
  parameter int unsigned N_STAGES  = 3,
  parameter int unsigned CNT_WIDTH = 8
);
  logic [N_STAGES-1:0]  cfg_bypass_in;
  logic                 cfg_valid_in;
  logic                 cfg_ready_out;
  logic [N_STAGES-1:0]  bypass_out;
  logic                 up_valid_in;
  logic                 up_ready_out;
  logic                 duc_valid_out;
  logic                 duc_ready_in;
  logic                 mon_valid_in;
  logic                 mon_ready_in;
  logic                 busy_out;
  logic [CNT_WIDTH-1:0] outstanding_out;
  logic                 timeout_err_out;

  modport slave (
    input  cfg_bypass_in, cfg_valid_in, up_valid_in, duc_ready_in, mon_valid_in, mon_ready_in,
    output cfg_ready_out, bypass_out, up_ready_out, duc_valid_out, busy_out, outstanding_out,
    timeout_err_out
  );

  modport master (
    output cfg_bypass_in, cfg_valid_in, up_valid_in, duc_ready_in, mon_valid_in, mon_ready_in,
    input  cfg_ready_out, bypass_out, up_ready_out, duc_valid_out, busy_out, outstanding_out,
    timeout_err_out
  );
endinterface

// File: rtl/duc_bypass_ctrl.sv
// Bypass reconfiguration sequencer for the x2 interpolator chain: stall, drain, settle, apply.
// Optional drain timeout is enabled by defining DUC_BYPASS_CTRL_TIMEOUT_EN.
module duc_bypass_ctrl #(
  parameter int unsigned         N_STAGES       = 3,
  parameter int unsigned         CNT_WIDTH      = 8,
  parameter int unsigned         SETTLE_CYCLES  = 4,
  parameter logic [N_STAGES-1:0] RESET_BYPASS   = '0,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              arst_n,
  duc_bypass_ctrl_if.slave bus
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StApply  = 2'd3;

  // Wide enough to hold count + largest ratio without overflow in the gate compare.
  localparam int unsigned SumW  = CNT_WIDTH + N_STAGES + 1;
  localparam int unsigned ZeroW = $clog2(N_STAGES + 1);
  localparam logic [SumW-1:0] CntMax = {{(N_STAGES + 1){1'b0}}, {CNT_WIDTH{1'b1}}};

  if (SETTLE_CYCLES > 255 || TIMEOUT_CYCLES == 0 || N_STAGES == 0) begin : g_bad_params
    $error("duc_bypass_ctrl: parameter out of range");
  end

  logic [1:0]           state_q, state_d;
  logic [N_STAGES-1:0]  bypass_q, bypass_d;
  logic [N_STAGES-1:0]  pending_q, pending_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [7:0]           settle_q, settle_d;

  logic [ZeroW-1:0]     zero_cnt;
  logic [SumW-1:0]      ratio;
  logic                 gate;
  logic                 in_acc;
  logic                 out_acc;
  logic                 cfg_acc;
  logic                 timeout_fire;

  // Each bypassed stage removes one x2 factor from the output/input sample ratio.
  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      zero_cnt = zero_cnt + ZeroW'(!bypass_q[i]);
    end
    ratio = SumW'(1) << zero_cnt;
  end

  assign gate    = (state_q == StRun) && ((SumW'(cnt_q) + ratio) <= CntMax);
  assign in_acc  = bus.up_valid_in & gate & bus.duc_ready_in;
  assign out_acc = bus.mon_valid_in & bus.mon_ready_in;
  assign cfg_acc = bus.cfg_valid_in & (state_q == StRun);

  always_comb begin
    cnt_nxt = cnt_q + (in_acc ? ratio[CNT_WIDTH-1:0] : '0);
    if (out_acc && (cnt_nxt != '0)) begin
      cnt_nxt = cnt_nxt - CNT_WIDTH'(1);
    end
    cnt_d = timeout_fire ? '0 : cnt_nxt;
  end

`ifdef DUC_BYPASS_CTRL_TIMEOUT_EN
  localparam int unsigned DrainW = $clog2(TIMEOUT_CYCLES + 1);

  logic [DrainW-1:0] drain_q, drain_d;
  logic              timeout_err_q, timeout_err_d;

  // A drain that completes in the same cycle as the limit is a normal exit, not a timeout.
  assign timeout_fire = (state_q == StDrain) && (drain_q == DrainW'(TIMEOUT_CYCLES - 1)) &&
                        (cnt_nxt != '0);

  always_comb begin
    drain_d       = drain_q;
    timeout_err_d = timeout_err_q;
    if (cfg_acc) begin
      drain_d       = '0;
      timeout_err_d = 1'b0;
    end else if (state_q == StDrain) begin
      drain_d = drain_q + DrainW'(1);
    end
    if (timeout_fire) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      drain_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      drain_q       <= drain_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err_out = timeout_err_q;
`else
  assign timeout_fire        = 1'b0;
  assign bus.timeout_err_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bypass_d  = bypass_q;
    pending_d = pending_q;
    settle_d  = settle_q;
    case (state_q)
      StRun: begin
        if (cfg_acc) begin
          pending_d = bus.cfg_bypass_in;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if ((cnt_nxt == '0) || timeout_fire) begin
          state_d  = StSettle;
          settle_d = 8'(SETTLE_CYCLES);
        end
      end
      StSettle: begin
        if (settle_q == 8'd0) begin
          state_d = StApply;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      StApply: begin
        bypass_d = pending_q;
        state_d  = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StRun;
      bypass_q  <= RESET_BYPASS;
      pending_q <= RESET_BYPASS;
      cnt_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      bypass_q  <= bypass_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
    end
  end

  assign bus.duc_valid_out   = bus.up_valid_in & gate;
  assign bus.up_ready_out    = bus.duc_ready_in & gate;
  assign bus.cfg_ready_out   = (state_q == StRun);
  assign bus.busy_out        = (state_q != StRun);
  assign bus.bypass_out      = bypass_q;
  assign bus.outstanding_out = cnt_q;

endmodule

// File: tb/tb_duc_bypass_ctrl.sv
// Directed self-checking bench for duc_bypass_ctrl (default build; timeout scenario runs
// only when DUC_BYPASS_CTRL_TIMEOUT_EN is defined).
module tb_duc_bypass_ctrl;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_pass;

  duc_bypass_ctrl_if #(.N_STAGES(3), .CNT_WIDTH(8)) bus ();

  duc_bypass_ctrl #(
    .N_STAGES      (3),
    .CNT_WIDTH     (8),
    .SETTLE_CYCLES (4),
    .RESET_BYPASS  (3'b000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the accept edge, controller in DRAIN.
  task automatic do_cfg(input logic [2:0] word);
    bus.cfg_bypass_in = word;
    bus.cfg_valid_in  = 1'b1;
    tick();
    bus.cfg_valid_in  = 1'b0;
  endtask

  task automatic test_reset();
    arst_n            = 1'b0;
    bus.cfg_bypass_in = 3'b000;
    bus.cfg_valid_in  = 1'b0;
    bus.up_valid_in   = 1'b1;
    bus.duc_ready_in  = 1'b1;
    bus.mon_valid_in  = 1'b0;
    bus.mon_ready_in  = 1'b0;
    #12;
    n_checks++;
    if (bus.bypass_out !== 3'b000) $display("FAIL reset_bypass: got %b want 000", bus.bypass_out);
    else n_pass++;
    n_checks++;
    if (bus.outstanding_out !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", bus.outstanding_out);
    else n_pass++;
    n_checks++;
    if ({bus.busy_out, bus.cfg_ready_out, bus.timeout_err_out} !== 3'b010)
      $display("FAIL reset_flags: got busy/cfgrdy/err=%b want 010",
               {bus.busy_out, bus.cfg_ready_out, bus.timeout_err_out});
    else n_pass++;
    n_checks++;
    if ({bus.up_ready_out, bus.duc_valid_out} !== 2'b11)
      $display("FAIL reset_gate: got uprdy/ducvld=%b want 11", {bus.up_ready_out, bus.duc_valid_out});
    else n_pass++;
    bus.up_valid_in = 1'b0;
    #11;
    arst_n = 1'b1;
    tick();
  endtask

  // R=8 with bypass 000: three inputs make 24 outstanding, 24 outputs drain it.
  task automatic test_fill();
    bus.mon_valid_in = 1'b1;
    bus.mon_ready_in = 1'b0;
    bus.up_valid_in  = 1'b1;
    tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd8) $display("FAIL fill_first: got %0d want 8", bus.outstanding_out);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd24) $display("FAIL fill_24: got %0d want 24", bus.outstanding_out);
    else n_pass++;
    bus.up_valid_in  = 1'b0;
    bus.mon_ready_in = 1'b1;
    repeat (23) tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd1) $display("FAIL drain_1: got %0d want 1", bus.outstanding_out);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd0) $display("FAIL drain_0: got %0d want 0", bus.outstanding_out);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd0) $display("FAIL drain_sat: got %0d want 0", bus.outstanding_out);
    else n_pass++;
    bus.mon_ready_in = 1'b0;
  endtask

  task automatic test_cfg_idle();
    n_checks++;
    if (bus.cfg_ready_out !== 1'b1) $display("FAIL idle_cfgrdy: got %b want 1", bus.cfg_ready_out);
    else n_pass++;
    do_cfg(3'b101);
    n_checks++;
    if ({bus.busy_out, bus.cfg_ready_out, bus.up_ready_out} !== 3'b100)
      $display("FAIL idle_drain: got busy/cfgrdy/uprdy=%b want 100",
               {bus.busy_out, bus.cfg_ready_out, bus.up_ready_out});
    else n_pass++;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if ({bus.busy_out, bus.bypass_out} !== 4'b1000)
        $display("FAIL idle_wait%0d: got busy/bypass=%b want 1000", i, {bus.busy_out, bus.bypass_out});
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({bus.busy_out, bus.bypass_out} !== 4'b0101)
      $display("FAIL idle_apply: got busy/bypass=%b want 0101", {bus.busy_out, bus.bypass_out});
    else n_pass++;
    bus.up_valid_in = 1'b1;
    tick();
    bus.up_valid_in = 1'b0;
    n_checks++;
    if (bus.outstanding_out !== 8'd2) $display("FAIL r2_add: got %0d want 2", bus.outstanding_out);
    else n_pass++;
  endtask

  task automatic test_cfg_drain();
    bus.mon_valid_in = 1'b1;
    bus.up_valid_in  = 1'b1;
    tick();
    tick();
    bus.up_valid_in  = 1'b0;
    bus.mon_ready_in = 1'b1;
    tick();
    bus.mon_ready_in = 1'b0;
    n_checks++;
    if (bus.outstanding_out !== 8'd5) $display("FAIL pre_drain: got %0d want 5", bus.outstanding_out);
    else n_pass++;
    do_cfg(3'b111);
    bus.up_valid_in = 1'b1;
    #1;
    n_checks++;
    if ({bus.up_ready_out, bus.duc_valid_out} !== 2'b00)
      $display("FAIL drain_gate: got uprdy/ducvld=%b want 00", {bus.up_ready_out, bus.duc_valid_out});
    else n_pass++;
    bus.mon_ready_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if ({bus.outstanding_out, bus.bypass_out, bus.up_ready_out} !== {8'(5 - k), 3'b101, 1'b0})
        $display("FAIL drain_step%0d: got cnt=%0d bypass=%b uprdy=%b want cnt=%0d bypass=101 uprdy=0",
                 k, bus.outstanding_out, bus.bypass_out, bus.up_ready_out, 5 - k);
      else n_pass++;
    end
    bus.mon_ready_in = 1'b0;
    bus.up_valid_in  = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if ({bus.busy_out, bus.bypass_out} !== 4'b1101)
        $display("FAIL drain_settle%0d: got busy/bypass=%b want 1101", i, {bus.busy_out, bus.bypass_out});
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({bus.busy_out, bus.bypass_out} !== 4'b0111)
      $display("FAIL drain_apply: got busy/bypass=%b want 0111", {bus.busy_out, bus.bypass_out});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_cfg(3'b000);
    repeat (7) tick();
    n_checks++;
    if ({bus.busy_out, bus.bypass_out} !== 4'b0000)
      $display("FAIL r8_apply: got busy/bypass=%b want 0000", {bus.busy_out, bus.bypass_out});
    else n_pass++;
    bus.up_valid_in = 1'b1;
    tick();
    tick();
    bus.up_valid_in  = 1'b0;
    bus.mon_ready_in = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd10) $display("FAIL pre_simul: got %0d want 10", bus.outstanding_out);
    else n_pass++;
    bus.up_valid_in = 1'b1;
    tick();
    bus.up_valid_in = 1'b0;
    n_checks++;
    if (bus.outstanding_out !== 8'd17) $display("FAIL simul: got %0d want 17", bus.outstanding_out);
    else n_pass++;
    repeat (7) tick();
    bus.mon_ready_in = 1'b0;
    bus.up_valid_in  = 1'b1;
    repeat (30) tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd250) $display("FAIL fill_250: got %0d want 250", bus.outstanding_out);
    else n_pass++;
    n_checks++;
    if ({bus.up_ready_out, bus.duc_valid_out} !== 2'b00)
      $display("FAIL full_gate: got uprdy/ducvld=%b want 00", {bus.up_ready_out, bus.duc_valid_out});
    else n_pass++;
    bus.up_valid_in  = 1'b0;
    bus.mon_ready_in = 1'b1;
    for (int c = 249; c >= 247; c--) begin
      tick();
      n_checks++;
      if ({bus.outstanding_out, bus.up_ready_out} !== {8'(c), (c <= 247)})
        $display("FAIL full_release%0d: got cnt=%0d uprdy=%b want uprdy=%b", c,
                 bus.outstanding_out, bus.up_ready_out, (c <= 247));
      else n_pass++;
    end
    bus.mon_ready_in = 1'b0;
    bus.up_valid_in  = 1'b1;
    tick();
    n_checks++;
    if ({bus.outstanding_out, bus.up_ready_out} !== {8'd255, 1'b0})
      $display("FAIL fill_255: got cnt=%0d uprdy=%b want 255/0", bus.outstanding_out, bus.up_ready_out);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.outstanding_out !== 8'd255) $display("FAIL no_wrap: got %0d want 255", bus.outstanding_out);
    else n_pass++;
    bus.up_valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.mon_ready_in = 1'b1;
    repeat (255) tick();
    bus.mon_ready_in = 1'b0;
    n_checks++;
    if (bus.outstanding_out !== 8'd0) $display("FAIL drain_255: got %0d want 0", bus.outstanding_out);
    else n_pass++;
    do_cfg(3'b110);
    repeat (7) tick();
    n_checks++;
    if (bus.bypass_out !== 3'b110) $display("FAIL pre_reset_bypass: got %b want 110", bus.bypass_out);
    else n_pass++;
    do_cfg(3'b011);
    tick();
    tick();
    #2;
    arst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.bypass_out, bus.busy_out, bus.cfg_ready_out, bus.outstanding_out} !== {3'b000, 1'b0, 1'b1, 8'd0})
      $display("FAIL mid_reset: got bypass=%b busy=%b cfgrdy=%b cnt=%0d want 000/0/1/0",
               bus.bypass_out, bus.busy_out, bus.cfg_ready_out, bus.outstanding_out);
    else n_pass++;
    #1;
    arst_n = 1'b1;
    repeat (8) tick();
    n_checks++;
    if ({bus.busy_out, bus.bypass_out} !== 4'b0000)
      $display("FAIL pending_discard: got busy/bypass=%b want 0000", {bus.busy_out, bus.bypass_out});
    else n_pass++;
  endtask

`ifdef DUC_BYPASS_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bus.mon_valid_in = 1'b1;
    bus.up_valid_in  = 1'b1;
    tick();
    bus.up_valid_in  = 1'b0;
    bus.mon_ready_in = 1'b1;
    repeat (5) tick();
    bus.mon_ready_in = 1'b0;
    bus.mon_valid_in = 1'b0;
    do_cfg(3'b111);
    repeat (15) tick();
    n_checks++;
    if ({bus.busy_out, bus.timeout_err_out, bus.outstanding_out} !== {1'b1, 1'b0, 8'd3})
      $display("FAIL to_wait: got busy=%b err=%b cnt=%0d want 1/0/3",
               bus.busy_out, bus.timeout_err_out, bus.outstanding_out);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.timeout_err_out, bus.outstanding_out} !== {1'b1, 8'd0})
      $display("FAIL to_fire: got err=%b cnt=%0d want 1/0", bus.timeout_err_out, bus.outstanding_out);
    else n_pass++;
    repeat (6) tick();
    n_checks++;
    if ({bus.busy_out, bus.bypass_out, bus.timeout_err_out} !== 5'b01111)
      $display("FAIL to_apply: got busy/bypass/err=%b want 01111",
               {bus.busy_out, bus.bypass_out, bus.timeout_err_out});
    else n_pass++;
    do_cfg(3'b000);
    n_checks++;
    if (bus.timeout_err_out !== 1'b0) $display("FAIL to_clear: got %b want 0", bus.timeout_err_out);
    else n_pass++;
    repeat (7) tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fill();
    test_cfg_idle();
    test_cfg_drain();
    test_back_to_back();
    test_reset_mid();
`ifdef DUC_BYPASS_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
